// File: rtl/data_mem_sized.sv
// -----------------------------------------------------------------------------
// data_mem_sized
//   Byte-addressed, little-endian data memory for the single-cycle MIPS
//   datapath. It supports byte, half and word accesses. Loads are sign- or
//   zero-extended. Read responses are registered and carry an ack/err
//   handshake. After reset, a hardware sweep can zero the array.
//
// Parameters
//   DEPTH        number of 32-bit words (power of 2, >= 2)
//   ADDR_W       width of the byte address
//   CLEAR_ON_RST 1: zero-sweep after reset, 0: contents untouched, no sweep
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req       access request, sampled when busy=0
//   we        1 = store, 0 = load
//   size      00 byte, 01 half, 10 word, 11 illegal
//   sign_ext  loads only: 1 sign-extends, 0 zero-extends
//   A         byte address
//   WD        right-aligned store data
//   RD        registered load data
//   ack       one-cycle response pulse per accepted request
//   err       valid with ack: request rejected
//   busy      clear sweep in progress, requests ignored
// -----------------------------------------------------------------------------
module data_mem_sized #(
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 32,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  // Byte size of the array, one bit wider than A so DEPTH*4 always fits.
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  cnt;
  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              accept;
  logic              bad;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       word_rd;
  logic [7:0]        byte_rd;
  logic [15:0]       half_rd;
  logic [31:0]       load_data;

  assign idx  = A[IDX_W+1:2];
  assign lane = A[1:0];
  assign busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Request decode: acceptance, error priority, byte enables, load extraction
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    bad       = 1'b0;
    be        = 4'b0000;
    wdata     = WD;
    load_data = '0;

    accept = (state == ST_READY) && req;

    // The checks run in priority order. Only the first match matters, because
    // every error gets the same response.
    if (size == 2'b11)                              bad = 1'b1;
    else if ({1'b0, A} >= MEM_BYTES)                bad = 1'b1;
    else if (size == SZ_HALF && A[0])               bad = 1'b1;
    else if (size == SZ_WORD && A[1:0] != 2'b00)    bad = 1'b1;

    // Store data is replicated across the lanes. The byte enables then pick
    // which lanes are actually written.
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{WD[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase

    word_rd = mem[idx];
    byte_rd = word_rd[8*lane +: 8];
    half_rd = lane[1] ? word_rd[31:16] : word_rd[15:0];

    case (size)
      SZ_BYTE: load_data = sign_ext ? {{24{byte_rd[7]}}, byte_rd}  : {24'h0, byte_rd};
      SZ_HALF: load_data = sign_ext ? {{16{half_rd[15]}}, half_rd} : {16'h0, half_rd};
      default: load_data = word_rd;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array. The clear sweep and normal stores share one write port.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; the clear sweep zeroes it over DEPTH cycles,
  // which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so all registers update from
  // pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (cnt == LAST_IDX) state_next = ST_READY;
      default:  state_next = ST_READY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response register: ack/err pulse, RD holds between loads
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD  <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= accept;
      err <= accept && bad;
      if (accept) begin
        if (bad)      RD <= '0;
        else if (!we) RD <= load_data;
      end
    end
  end

endmodule
